// File: rtl/dispatch_4_32bit_if.sv
// Handshake bundle for the 4-way result dispatcher: one input stream and four held output ports.
// The dispatcher itself connects through the slave modport; the surrounding environment uses master.
interface dispatch_4_32bit_if;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data0;
  logic [31:0] out_data1;
  logic [31:0] out_data2;
  logic [31:0] out_data3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data0, out_data1, out_data2, out_data3, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data0, out_data1, out_data2, out_data3, out_valid
  );
endinterface

// File: rtl/dispatch_4_32bit.sv
// Routes one 32-bit result per cycle into one of four one-entry holding ports (ALU, MEM, JAL, CMOV).
// Define DISPATCH_STATS_EN to add saturating per-port delivery counters cnt0..cnt3.
module dispatch_4_32bit #(
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  dispatch_4_32bit_if.slave bus
`ifdef DISPATCH_STATS_EN
  ,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic [CNT_W-1:0]  cnt2,
  output logic [CNT_W-1:0]  cnt3
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } portState_t;

  portState_t  r_state [4];
  logic [31:0] r_data  [4];
  logic [3:0]  w_valid;
  logic [3:0]  w_deliver;
  logic        w_accept;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_valid[k] = (r_state[k] == FULL);
    end
  end

  // A full port may still accept when it is being drained in the same cycle (no bubble).
  assign w_deliver     = w_valid & bus.out_ready;
  assign bus.in_ready  = ~w_valid[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign w_accept      = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        r_state[k] <= EMPTY;
        r_data[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_accept && (bus.in_sel == 2'(k))) begin
          r_state[k] <= FULL;
          r_data[k]  <= bus.in_data;
        end else if (w_deliver[k]) begin
          r_state[k] <= EMPTY;
        end
      end
    end
  end

  assign bus.out_valid = w_valid;
  assign bus.out_data0 = r_data[0];
  assign bus.out_data1 = r_data[1];
  assign bus.out_data2 = r_data[2];
  assign bus.out_data3 = r_data[3];

`ifdef DISPATCH_STATS_EN
  logic [CNT_W-1:0] r_cnt [4];

  // Counters stop at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_deliver[k] && (r_cnt[k] != {CNT_W{1'b1}})) begin
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  assign cnt0 = r_cnt[0];
  assign cnt1 = r_cnt[1];
  assign cnt2 = r_cnt[2];
  assign cnt3 = r_cnt[3];
`endif

endmodule

// File: tb/tb_dispatch_4_32bit.sv
// Self-checking bench for dispatch_4_32bit: directed scenarios plus random traffic against an occupancy model.
// Build with DISPATCH_STATS_EN defined to also check the delivery counters.
module tb_dispatch_4_32bit;

  localparam int CNT_W  = 2;
  localparam int CntMax = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  dispatch_4_32bit_if bus ();

`ifdef DISPATCH_STATS_EN
  logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;
`endif

  dispatch_4_32bit #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DISPATCH_STATS_EN
    ,
    .cnt0(cnt0),
    .cnt1(cnt1),
    .cnt2(cnt2),
    .cnt3(cnt3)
`endif
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;
  bit checkEn = 1'b0;

  // Model: each port holds at most one word; track occupancy, last word written and deliveries.
  int          mCount [4];
  logic [31:0] mLast  [4];
  int          mCnt   [4];
  int          mSel;
  bit          mAcc;
  logic [3:0]  expValid;
  logic [31:0] outData [4];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [1:0] s,
                               input logic [31:0] d, input logic [3:0] rdy);
    rst          = r;
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_data  = d;
    bus.out_ready = rdy;
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      mCount[k] = 0;
      mLast[k]  = '0;
      mCnt[k]   = 0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        mCount[k] = 0;
        mLast[k]  = '0;
        mCnt[k]   = 0;
      end
    end else begin
      mSel = int'(bus.in_sel);
      mAcc = bus.in_valid && ((mCount[mSel] == 0) || bus.out_ready[mSel]);
      for (int k = 0; k < 4; k++) begin
        if ((mCount[k] > 0) && bus.out_ready[k]) begin
          mCount[k] = mCount[k] - 1;
          if (mCnt[k] < CntMax) mCnt[k] = mCnt[k] + 1;
        end
      end
      if (mAcc) begin
        mCount[mSel] = mCount[mSel] + 1;
        mLast[mSel]  = bus.in_data;
      end
    end
  end

  // Every cycle, compare all outputs against the model at the falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int k = 0; k < 4; k++) expValid[k] = (mCount[k] != 0);
      outData[0] = bus.out_data0;
      outData[1] = bus.out_data1;
      outData[2] = bus.out_data2;
      outData[3] = bus.out_data3;
      checkOutput("model_out_valid", 64'(bus.out_valid), 64'(expValid));
      checkOutput("model_in_ready", 64'(bus.in_ready),
                  64'((mCount[int'(bus.in_sel)] == 0) || bus.out_ready[bus.in_sel]));
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("model_out_data%0d", k), 64'(outData[k]), 64'(mLast[k]));
      end
`ifdef DISPATCH_STATS_EN
      checkOutput("model_cnt0", 64'(cnt0), 64'(mCnt[0]));
      checkOutput("model_cnt1", 64'(cnt1), 64'(mCnt[1]));
      checkOutput("model_cnt2", 64'(cnt2), 64'(mCnt[2]));
      checkOutput("model_cnt3", 64'(cnt3), 64'(mCnt[3]));
`endif
    end
  end

  initial begin
    applyStimulus(1'b1, 1'b1, 2'd1, 32'h1234_5678, 4'hF);
    step(1);
    checkEn = 1'b1;
    step(1);

    // Reset state and readiness right after reset release.
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_out_data1", 64'(bus.out_data1), 64'd0);

    // Single word to the JAL port.
    applyStimulus(1'b0, 1'b1, 2'd2, 32'hDEAD_BEEF, 4'h0);
    step(1);
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    checkOutput("jal_out_valid", 64'(bus.out_valid), 64'b0100);
    checkOutput("jal_out_data2", 64'(bus.out_data2), 64'hDEAD_BEEF);
    checkOutput("jal_out_data0", 64'(bus.out_data0), 64'd0);
    checkOutput("jal_out_data3", 64'(bus.out_data3), 64'd0);

    // Stall on port 1, then back-to-back replacement.
    applyStimulus(1'b0, 1'b1, 2'd1, 32'h11, 4'h0);
    step(1);
    applyStimulus(1'b0, 1'b1, 2'd1, 32'h22, 4'h0);
    checkOutput("stall_in_ready", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      checkOutput("stall_out_data1", 64'(bus.out_data1), 64'h11);
      checkOutput("stall_in_ready_hold", 64'(bus.in_ready), 64'd0);
    end
    applyStimulus(1'b0, 1'b1, 2'd1, 32'h22, 4'b0010);
    checkOutput("drain_in_ready", 64'(bus.in_ready), 64'd1);
    step(1);
    checkOutput("b2b_out_data1", 64'(bus.out_data1), 64'h22);
    checkOutput("b2b_out_valid", 64'(bus.out_valid), 64'b0110);
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 4'b0010);
    step(1);
    checkOutput("drained_out_valid", 64'(bus.out_valid), 64'b0100);

    // Streaming into the ALU port with its consumer always ready.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 1'b1, 2'd0, 32'(i), 4'b0001);
      checkOutput("stream_in_ready", 64'(bus.in_ready), 64'd1);
      step(1);
      checkOutput("stream_out_data0", 64'(bus.out_data0), 64'(i));
      checkOutput("stream_out_valid0", 64'(bus.out_valid[0]), 64'd1);
    end
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 4'b0001);
    step(1);
    checkOutput("stream_end_out_valid", 64'(bus.out_valid), 64'b0100);

    // Port 3 stalled must not be disturbed by traffic to port 0.
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h50, 4'h0);
    step(1);
    applyStimulus(1'b0, 1'b1, 2'd3, 32'h33, 4'h0);
    step(1);
    applyStimulus(1'b0, 1'b1, 2'd0, 32'hA5, 4'b0001);
    checkOutput("iso_in_ready", 64'(bus.in_ready), 64'd1);
    step(1);
    checkOutput("iso_out_data0", 64'(bus.out_data0), 64'hA5);
    checkOutput("iso_out_data3", 64'(bus.out_data3), 64'h33);
    checkOutput("iso_out_valid", 64'(bus.out_valid), 64'b1101);

    // Reset with every port full and a word offered.
    applyStimulus(1'b0, 1'b1, 2'd1, 32'h77, 4'h0);
    step(1);
    checkOutput("full_out_valid", 64'(bus.out_valid), 64'b1111);
    applyStimulus(1'b1, 1'b1, 2'd1, 32'h99, 4'h0);
    step(1);
    checkOutput("rstfull_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rstfull_out_data1", 64'(bus.out_data1), 64'd0);
    checkOutput("rstfull_out_data2", 64'(bus.out_data2), 64'd0);
    checkOutput("rstfull_out_data3", 64'(bus.out_data3), 64'd0);

`ifdef DISPATCH_STATS_EN
    // Five deliveries on port 3 saturate a 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 2'd3, 32'(i + 100), 4'b1000);
      step(1);
    end
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 4'b1000);
    step(1);
    checkOutput("sat_cnt3", 64'(cnt3), 64'b11);
    checkOutput("sat_cnt0", 64'(cnt0), 64'd0);
    checkOutput("sat_cnt2", 64'(cnt2), 64'd0);
`endif

    // Random traffic, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                    2'($urandom_range(0, 3)), $urandom(), 4'($urandom_range(0, 15)));
      step(1);
    end

    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
